// File: rtl/bn_normalize_pkg.sv
// Shared FP16 constants, state encodings and the floatAdd/floatMult cores used by the batch-norm stages.
// The cores are combinational; denormals flush to zero and results round to nearest-even.
package bn_normalize_pkg;

  localparam logic [15:0] FP16_HALF         = 16'h3800;
  localparam logic [15:0] FP16_THREE_HALVES = 16'h3E00;
  localparam logic [15:0] FP16_RSQRT_MAGIC  = 16'h59BB;
  localparam logic [15:0] BN_EPS_DEFAULT    = 16'h1400;
  localparam logic [15:0] FP16_QNAN         = 16'h7E00;

  typedef enum logic [2:0] {S_IDLE, S_EPS, S_SEED, S_NR, S_SCALE, S_NORM, S_DONE} bn_state_t;
  typedef enum logic [1:0] {P_IDLE, P_SEED, P_NR} rsqrt_phase_t;

  // m carries the significand with its leading one at bit 21; bits below 11 are round/sticky.
  function automatic logic [15:0] fp16_pack(input logic s, input logic signed [7:0] e,
                                            input logic [21:0] m);
    logic             rnd;
    logic [11:0]      rm;
    logic signed [7:0] en;
    rnd = m[10] & ((|m[9:0]) | m[11]);
    rm  = {1'b0, m[21:11]} + {11'd0, rnd};
    en  = rm[11] ? e + 8'sd1 : e;
    if (en >= 8'sd31) return {s, 5'h1F, 10'd0};
    if (en <= 8'sd0) return {s, 15'd0};
    return {s, en[4:0], rm[11] ? rm[10:1] : rm[9:0]};
  endfunction

  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic              s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [21:0]       p;
    logic signed [7:0] e;
    s      = a[15] ^ b[15];
    a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    a_zero = (a[14:10] == 5'd0);
    b_zero = (b[14:10] == 5'd0);
    p = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
    e = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return FP16_QNAN;
    if (a_inf || b_inf) return {s, 5'h1F, 10'd0};
    if (a_zero || b_zero) return {s, 15'd0};
    if (p[21]) return fp16_pack(s, e + 8'sd1, p);
    return fp16_pack(s, e, {p[20:0], 1'b0});
  endfunction

  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic              a_nan, b_nan, a_inf, b_inf;
    logic [15:0]       big, sml;
    logic [4:0]        d, lz;
    logic [22:0]       mb, ms, sum;
    logic signed [7:0] e;
    a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    if (a[14:0] >= b[14:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    d  = big[14:10] - sml[14:10];
    mb = {2'b01, big[9:0], 11'd0};
    ms = {2'b01, sml[9:0], 11'd0} >> d;
    e  = $signed({3'b000, big[14:10]});
    lz = 5'd0;
    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) return FP16_QNAN;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a[14:10] == 5'd0) return (b[14:10] == 5'd0) ? {a[15] & b[15], 15'd0} : b;
    if (b[14:10] == 5'd0) return a;
    if (big[15] == sml[15]) begin
      sum = mb + ms;
      if (sum[22]) return fp16_pack(big[15], e + 8'sd1, {sum[22:2], sum[1] | sum[0]});
      return fp16_pack(big[15], e, sum[21:0]);
    end
    sum = mb - ms;
    if (sum == 23'd0) return 16'h0000;
    for (int i = 0; i < 22; i++) if (sum[i]) lz = 5'(21 - i);
    return fp16_pack(big[15], e - $signed({3'b000, lz}), sum[21:0] << lz);
  endfunction

endpackage

// File: rtl/bn_rsqrt_nr.sv
// rsqrt(var+EPS): EPS add, magic-number seed, then NR_ITERS Newton-Raphson steps of 4 cycles each.
// done pulses on the cycle the final r update is written; start is taken only between runs.
module bn_rsqrt_nr
  import bn_normalize_pkg::*;
#(
  parameter int          NR_ITERS = 2,
  parameter logic [15:0] EPS      = BN_EPS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] var_in,
  output logic        done,
  output logic [15:0] r
);

  rsqrt_phase_t phase;
  logic [15:0]  v, h, t, r_q;
  logic [1:0]   sub, iter;
  logic [15:0]  mul_a, mul_b, mul_y, add_a, add_b, add_y;

  always_comb begin
    mul_a = r_q;
    mul_b = r_q;
    add_a = FP16_THREE_HALVES;
    add_b = {~t[15], t[14:0]};
    if (start) begin
      // a negative variance is treated as +0 so the result is rsqrt(EPS)
      add_a = var_in[15] ? 16'h0000 : var_in;
      add_b = EPS;
    end else if (phase == P_SEED) begin
      mul_a = v;
      mul_b = FP16_HALF;
    end else if (sub == 2'd1) begin
      mul_a = t;
      mul_b = h;
    end else if (sub == 2'd3) begin
      mul_b = t;
    end
    mul_y = fp16_mul(mul_a, mul_b);
    add_y = fp16_add(add_a, add_b);
    done  = (phase == P_NR) && (sub == 2'd3) && (iter == 2'(NR_ITERS - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase <= P_IDLE;
      v     <= 16'd0;
      h     <= 16'd0;
      t     <= 16'd0;
      r_q   <= 16'd0;
      sub   <= 2'd0;
      iter  <= 2'd0;
    end else if (start) begin
      v     <= add_y;
      phase <= P_SEED;
    end else begin
      case (phase)
        P_SEED: begin
          r_q   <= FP16_RSQRT_MAGIC - {1'b0, v[15:1]};
          h     <= mul_y;
          sub   <= 2'd0;
          iter  <= 2'd0;
          phase <= P_NR;
        end
        P_NR: begin
          case (sub)
            2'd2:    t   <= add_y;
            2'd3:    r_q <= mul_y;
            default: t   <= mul_y;
          endcase
          sub <= sub + 2'd1;
          if (done) phase <= P_IDLE;
          else if (sub == 2'd3) iter <= iter + 2'd1;
        end
        default: phase <= P_IDLE;
      endcase
    end
  end

  assign r = r_q;

endmodule

// File: rtl/bn_normalize.sv
// Batch-norm output: y_i = gamma*(x_i-u)*rsqrt(var+EPS) + beta, lanes serialised one per cycle.
// Accept to out_valid is 4 + 4*NR_ITERS + size cycles; y/out_valid hold in DONE until out_ready.
module bn_normalize
  import bn_normalize_pkg::*;
#(
  parameter int          DATA_WIDTH = 16,
  parameter int          size       = 4,
  parameter logic [15:0] EPS        = BN_EPS_DEFAULT,
  parameter int          NR_ITERS   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH*size-1:0] x,
  input  logic [DATA_WIDTH-1:0]      neg_mean,
  input  logic [DATA_WIDTH-1:0]      var_in,
  input  logic [DATA_WIDTH-1:0]      gamma,
  input  logic [DATA_WIDTH-1:0]      beta,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH*size-1:0] y
);

  localparam int LANE_W = (size > 1) ? $clog2(size) : 1;

  bn_state_t                 state, state_nx;
  logic [DATA_WIDTH*size-1:0] x_r, y_r;
  logic [DATA_WIDTH-1:0]     nm_r, var_r, gamma_r, beta_r, k_r;
  logic [LANE_W-1:0]         lane;
  logic                      accept, var_bad, rs_done;
  logic [15:0]               rs_r, x_lane, lane_sum, mul_a, mul_b, prod, y_lane;

  bn_rsqrt_nr #(.NR_ITERS(NR_ITERS), .EPS(EPS)) u_rsqrt (
    .clk    (clk),
    .reset  (reset),
    .start  (state == S_EPS),
    .var_in (var_r),
    .done   (rs_done),
    .r      (rs_r)
  );

  always_comb begin
    state_nx = state;
    in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    accept   = in_valid && in_ready;
    case (state)
      S_IDLE:  if (accept) state_nx = S_EPS;
      S_EPS:   state_nx = S_SEED;
      S_SEED:  state_nx = S_NR;
      S_NR:    if (rs_done) state_nx = S_SCALE;
      S_SCALE: state_nx = S_NORM;
      S_NORM:  if (lane == LANE_W'(size - 1)) state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = in_valid ? S_EPS : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // +Inf or +NaN variance has no meaningful scale; k is zeroed so every lane collapses to beta
  assign var_bad = (var_r[14:10] == 5'h1F) && !var_r[15];

  // The single multiplier serves gamma*r in SCALE and the per-lane product in NORM
  always_comb begin
    x_lane   = x_r[int'(lane)*DATA_WIDTH +: DATA_WIDTH];
    lane_sum = fp16_add(x_lane, nm_r);
    mul_a    = (state == S_SCALE) ? gamma_r : lane_sum;
    mul_b    = (state == S_SCALE) ? rs_r : k_r;
    prod     = fp16_mul(mul_a, mul_b);
    y_lane   = fp16_add(prod, beta_r);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      x_r     <= '0;
      y_r     <= '0;
      nm_r    <= '0;
      var_r   <= '0;
      gamma_r <= '0;
      beta_r  <= '0;
      k_r     <= '0;
      lane    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        x_r     <= x;
        nm_r    <= neg_mean;
        var_r   <= var_in;
        gamma_r <= gamma;
        beta_r  <= beta;
      end
      if (state == S_SCALE) begin
        k_r  <= var_bad ? 16'h0000 : prod;
        lane <= '0;
      end
      if (state == S_NORM) begin
        y_r[int'(lane)*DATA_WIDTH +: DATA_WIDTH] <= y_lane;
        lane <= lane + 1'b1;
      end
    end
  end

  assign out_valid = (state == S_DONE);
  assign y         = y_r;

endmodule

// File: tb/tb_bn_normalize.sv
// Directed bench for bn_normalize: reset, arithmetic cases, variance corner cases, backpressure, mid-run reset.
module tb_bn_normalize;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] x;
  logic [15:0] neg_mean, var_in, gamma, beta;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] y;

  int total_cnt = 0;
  int pass_cnt  = 0;

  localparam logic [63:0] X_BASIC   = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
  localparam logic [63:0] Y_BASIC   = {16'h3D5E, 16'h3727, 16'hB727, 16'hBD5E};
  localparam logic [63:0] X_CLAMP   = {16'h0000, 16'hBC00, 16'h3C00, 16'h2C00};
  localparam logic [63:0] Y_CLAMP   = {16'h0000, 16'hD000, 16'h5000, 16'h4000};
  localparam logic [63:0] X_BAD     = {16'h0000, 16'hC200, 16'h4000, 16'h3C00};

  bn_normalize dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .neg_mean  (neg_mean),
    .var_in    (var_in),
    .gamma     (gamma),
    .beta      (beta),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  always #5 clk = ~clk;

  function automatic int fp_ord(input logic [15:0] v);
    return v[15] ? -int'(v[14:0]) : int'(v[14:0]);
  endfunction

  // true when every lane of got is within 2 ULP of want
  function automatic bit lanes_close(input logic [63:0] got, input logic [63:0] want);
    bit ok = 1'b1;
    if ($isunknown(got)) return 1'b0;
    for (int i = 0; i < 4; i++) begin
      int d = fp_ord(got[i*16 +: 16]) - fp_ord(want[i*16 +: 16]);
      if (d > 2 || d < -2) ok = 1'b0;
    end
    return ok;
  endfunction

  // drive a vector at posedge+1 with the block idle; returns at posedge+1 of cycle 1
  task automatic send_vec(input logic [63:0] xv, input logic [15:0] nm, input logic [15:0] vr,
                          input logic [15:0] gm, input logic [15:0] bt);
    x        = xv;
    neg_mean = nm;
    var_in   = vr;
    gamma    = gm;
    beta     = bt;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x        = {$urandom, $urandom};
    neg_mean = 16'($urandom);
    var_in   = 16'($urandom);
    gamma    = 16'($urandom);
    beta     = 16'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (y !== 64'd0) $display("FAIL reset_y got %h want 0", y);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
    else pass_cnt++;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat;
    send_vec(X_BASIC, 16'hC100, 16'h3D00, 16'h3C00, 16'h0000);
    wait_out(lat);
    total_cnt++;
    if (lat !== 16) $display("FAIL basic_latency got %0d want 16", lat);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (!lanes_close({48'd0, y[i*16 +: 16]}, {48'd0, Y_BASIC[i*16 +: 16]}))
        $display("FAIL basic_lane%0d got %h want %h", i, y[i*16 +: 16], Y_BASIC[i*16 +: 16]);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL basic_handshake got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_zero_var;
    int lat;
    send_vec({4{16'h4000}}, 16'hC000, 16'h0000, 16'h3C00, 16'h3800);
    wait_out(lat);
    total_cnt++;
    if (lat !== 16) $display("FAIL zero_var_latency got %0d want 16", lat);
    else pass_cnt++;
    total_cnt++;
    if (y !== {4{16'h3800}}) $display("FAIL zero_var_y got %h want %h", y, {4{16'h3800}});
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_neg_var;
    int lat;
    send_vec(X_CLAMP, 16'h0000, 16'h8001, 16'h3C00, 16'h0000);
    wait_out(lat);
    total_cnt++;
    if (lat !== 16) $display("FAIL neg_var_latency got %0d want 16", lat);
    else pass_cnt++;
    total_cnt++;
    if (!lanes_close(y, Y_CLAMP)) $display("FAIL neg_var_y got %h want %h", y, Y_CLAMP);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_bad_var;
    int lat;
    logic [15:0] bad [2] = '{16'h7E00, 16'h7C00};
    for (int j = 0; j < 2; j++) begin
      send_vec(X_BAD, 16'hBC00, bad[j], 16'h3C00, 16'h4500);
      wait_out(lat);
      total_cnt++;
      if (lat !== 16) $display("FAIL bad_var%0d_latency got %0d want 16", j, lat);
      else pass_cnt++;
      total_cnt++;
      if (y !== {4{16'h4500}}) $display("FAIL bad_var%0d_y got %h want %h", j, y, {4{16'h4500}});
      else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    out_ready = 1'b0;
    send_vec(X_BASIC, 16'hC100, 16'h3D00, 16'h3C00, 16'h0000);
    wait_out(lat);
    total_cnt++;
    if (lat !== 16) $display("FAIL b2b_first_latency got %0d want 16", lat);
    else pass_cnt++;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || !lanes_close(y, Y_BASIC))
        $display("FAIL b2b_hold%0d got out_valid=%b in_ready=%b y=%h want 1/0/%h",
                 c, out_valid, in_ready, y, Y_BASIC);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    x         = {4{16'h4000}};
    neg_mean  = 16'hC000;
    var_in    = 16'h0000;
    gamma     = 16'h3C00;
    beta      = 16'h3800;
    in_valid  = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL b2b_in_ready got %b want 1", in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x        = {$urandom, $urandom};
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL b2b_out_valid_drop got %b want 0", out_valid);
    else pass_cnt++;
    wait_out(lat);
    total_cnt++;
    if (lat !== 16) $display("FAIL b2b_second_latency got %0d want 16", lat);
    else pass_cnt++;
    total_cnt++;
    if (y !== {4{16'h3800}}) $display("FAIL b2b_second_y got %h want %h", y, {4{16'h3800}});
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat;
    send_vec(X_BASIC, 16'hC100, 16'h3D00, 16'h3C00, 16'h0000);
    repeat (5) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    total_cnt++;
    if (out_valid !== 1'b0 || y !== 64'd0 || in_ready !== 1'b1)
      $display("FAIL mid_reset got out_valid=%b y=%h in_ready=%b want 0/0/1", out_valid, y, in_ready);
    else pass_cnt++;
    send_vec(X_CLAMP, 16'h0000, 16'h8001, 16'h3C00, 16'h0000);
    wait_out(lat);
    total_cnt++;
    if (lat !== 16) $display("FAIL mid_reset_latency got %0d want 16", lat);
    else pass_cnt++;
    total_cnt++;
    if (!lanes_close(y, Y_CLAMP)) $display("FAIL mid_reset_y got %h want %h", y, Y_CLAMP);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = 64'd0;
    neg_mean  = 16'd0;
    var_in    = 16'd0;
    gamma     = 16'd0;
    beta      = 16'd0;
    test_reset();
    test_basic();
    test_zero_var();
    test_neg_var();
    test_bad_var();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
